output_port_arbiter: RTL
========================

OUTPUT_PORT_ARBITER -- requirements
Module: output_port_arbiter

Interface
REQ-001 SHALL have parameter flit_size, default 4, bits per flit.
REQ-002 SHALL have parameter packet_size, default 32, bits per packet; flit_number = packet_size/flit_size (default 8).
REQ-003 SHALL have parameter port_number, default 5, number of requesting input ports (index 4 = local).
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  reset is synchronous and active-high.
REQ-006 SHALL have port request  input  port_number  per-port request: input port has a ready current address routed to this output.
REQ-007 SHALL have port flit_in  input  port_number*flit_size  concatenated flit buses; port i occupies bits [i*flit_size +: flit_size].
REQ-008 SHALL have port stall  output  port_number  per-port stall returned to each input port controller.
REQ-009 SHALL have port grant  output  port_number  one-hot registered grant, all-zero when no owner.
REQ-010 SHALL have port flit_out  output  flit_size  flit forwarded from granted port.
REQ-011 SHALL have port flit_valid  output  1  flit_out carries a valid flit this cycle.

Function
REQ-012 SHALL implement three states: IDLE, TRANSFER, RELEASE.
REQ-013 SHALL, in IDLE with request != 0, select the winner combinationally by round-robin, searching upward from priority pointer rr_ptr and wrapping at port_number-1 to 0.
REQ-014 SHALL, in the selection cycle, drive stall[winner]=0 and stall[i]=1 for every other requesting port; stall[i]=0 for non-requesting ports.
REQ-015 SHALL register grant=one-hot(winner), clear flit counter and enter TRANSFER on the edge ending the selection cycle.
REQ-016 SHALL, in TRANSFER, hold grant, drive stall[i]=request[i] for all i, flit_out=flit_in slice of granted port, flit_valid=1, and increment counter every cycle.
REQ-017 SHALL leave TRANSFER for RELEASE after exactly flit_number cycles (counter == flit_number-1); no mid-packet preemption.
REQ-018 SHALL, in RELEASE, drive grant=0, flit_valid=0, stall[i]=request[i], set rr_ptr=(winner+1) mod port_number, return to IDLE; one bubble cycle between packets.
REQ-019 SHALL keep rr_ptr unchanged while IDLE with no requests.
REQ-020 SHALL ignore request changes of the granted port during TRANSFER (packet length is fixed).
REQ-021 SHALL use a counter of clog2(flit_number)+1 bits; no wrap inside a packet.
REQ-022 SHALL drive flit_out=0 when flit_valid=0.

Reset
REQ-023 SHALL on reset (sampled at clk edge) force IDLE, grant=0, rr_ptr=0, counter=0, flit_valid=0, flit_out=0.
REQ-024 SHALL abort any in-flight packet on reset mid-TRANSFER with no further flit_valid; rr_ptr returns to 0.
REQ-025 SHALL hold stall output = 0 for all ports in the reset cycle.

Configuration
REQ-026 SHALL support macro OUTPUT_PORT_ARBITER_OUTREG_EN.
REQ-027 SHALL, with OUTPUT_PORT_ARBITER_OUTREG_EN defined, register flit_out/flit_valid (one extra cycle latency, cleared by reset); grant/stall timing unchanged.
REQ-028 SHALL, without the macro, drive flit_out/flit_valid combinationally from the granted flit_in slice (zero latency).

Verification
REQ-029 SHALL cover: after reset request=5'b00100 -> stall=0 same cycle, grant=5'b00100 next cycle, 8 cycles flit_valid=1 with port 2 data, then RELEASE, rr_ptr=3.
REQ-030 SHALL cover: request=5'b11111 held continuously from reset -> grant order ports 0,1,2,3,4,0, each 8 valid flits plus 1 bubble.
REQ-031 SHALL cover: port 1 granted, port 3 raises request mid-TRANSFER -> stall[3]=1 until RELEASE, port 3 granted next IDLE selection.
REQ-032 SHALL cover: reset asserted at TRANSFER flit 4 -> next cycle grant=0, flit_valid=0, state IDLE, rr_ptr=0.
REQ-033 SHALL cover: rr_ptr=4, request=5'b00001 -> wrap, port 0 wins; rr_ptr becomes 1 after release.
REQ-034 SHALL cover: OUTPUT_PORT_ARBITER_OUTREG_EN defined, single request -> flit_valid first high one cycle after grant, 8 consecutive flits unchanged in content.

Source files
------------

// File: rtl/output_port_arbiter.sv
// Round-robin arbiter granting one output port to a requesting input for a fixed-length packet.
// Define OUTPUT_PORT_ARBITER_OUTREG_EN to register flit_out/flit_valid (one cycle extra latency).
module output_port_arbiter #(
  parameter int flit_size   = 4,
  parameter int packet_size = 32,
  parameter int port_number = 5
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [port_number-1:0]            request,
  input  logic [port_number*flit_size-1:0]  flit_in,
  output logic [port_number-1:0]            stall,
  output logic [port_number-1:0]            grant,
  output logic [flit_size-1:0]              flit_out,
  output logic                              flit_valid
);

  localparam int flit_number = packet_size / flit_size;
  localparam int ptr_w       = $clog2(port_number);
  localparam int cnt_w       = $clog2(flit_number) + 1;

  localparam logic [ptr_w:0]   port_count = (ptr_w+1)'(port_number);
  localparam logic [ptr_w-1:0] ptr_last   = ptr_w'(port_number - 1);
  localparam logic [cnt_w-1:0] cnt_last   = cnt_w'(flit_number - 1);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] TRANSFER = 2'd1;
  localparam logic [1:0] RELEASE  = 2'd2;

  logic [1:0]             state;
  logic [ptr_w-1:0]       rr_ptr;
  logic [ptr_w-1:0]       owner;
  logic [ptr_w-1:0]       winner;
  logic [cnt_w-1:0]       count;
  logic [port_number-1:0] winner_onehot;
  logic [flit_size-1:0]   owner_flit;
  logic                   xfer_valid;

  // First requester at or above rr_ptr, wrapping past the last port.
  always_comb begin
    logic [ptr_w:0] idx;
    logic           found;
    winner = rr_ptr;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < port_number; k++) begin
      idx = {1'b0, rr_ptr} + (ptr_w+1)'(k);
      if (idx >= port_count) idx = idx - port_count;
      if (!found && request[idx[ptr_w-1:0]]) begin
        found  = 1'b1;
        winner = idx[ptr_w-1:0];
      end
    end
  end

  always_comb begin
    winner_onehot         = '0;
    winner_onehot[winner] = 1'b1;
  end

  assign owner_flit = flit_in[owner*flit_size +: flit_size];
  assign xfer_valid = (state == TRANSFER);

  always_comb begin
    stall = '0;
    if (!reset) begin
      case (state)
        IDLE:              stall = request & ~winner_onehot;
        TRANSFER, RELEASE: stall = request;
        default:           stall = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= '0;
      owner  <= '0;
      count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|request) begin
            grant <= winner_onehot;
            owner <= winner;
            count <= '0;
            state <= TRANSFER;
          end
        end
        TRANSFER: begin
          count <= count + cnt_w'(1);
          if (count == cnt_last) begin
            grant <= '0;
            state <= RELEASE;
          end
        end
        RELEASE: begin
          rr_ptr <= (owner == ptr_last) ? '0 : owner + ptr_w'(1);
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef OUTPUT_PORT_ARBITER_OUTREG_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      flit_valid <= 1'b0;
      flit_out   <= '0;
    end else begin
      flit_valid <= xfer_valid;
      flit_out   <= xfer_valid ? owner_flit : '0;
    end
  end
`else
  always_comb begin
    flit_valid = xfer_valid;
    flit_out   = xfer_valid ? owner_flit : '0;
  end
`endif

endmodule
